// File: rtl/tx_frame_sr_if.sv
// Valid/ready word handshake between a transmit producer and the serial framer.
interface tx_frame_sr_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/tx_frame_sr.sv
// UART-style transmit framer: one-entry holding buffer feeding a start/data/parity/stop
// serializer paced by an internal bit timer that freezes while tx_enable is low.
module tx_frame_sr #(
  parameter int DATA_BITS    = 8,
  parameter int SHIFT_MSB    = 0,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_enable,
  tx_frame_sr_if.slave bus,
  output logic         tx_out,
  output logic         tx_busy,
  output logic         frame_done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = 5;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 buf_full_q, buf_full_d;
  logic                 parity_q, parity_d;
  logic                 tx_out_q, tx_out_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 bit_end, frame_end, start_now;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    buf_full_d   = buf_full_q;
    parity_d     = parity_q;
    bit_end      = 1'b0;
    frame_end    = 1'b0;
    start_now    = 1'b0;

    if (state_q != IDLE && tx_enable) begin
      bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));
      timer_d = bit_end ? '0 : timer_q + TW'(1);
    end

    if (bit_end) begin
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d = (SHIFT_MSB != 0) ? {shift_q[DATA_BITS-2:0], 1'b0}
                                     : {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        PARITY: begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
        STOP: begin
          if (bit_cnt_q == CW'(STOP_BITS - 1)) begin
            frame_end = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end

    // A buffered word may start straight out of the last stop bit, giving no idle gap.
    start_now = buf_full_q && tx_enable && (state_q == IDLE || frame_end);
    if (start_now) begin
      state_d    = START;
      shift_d    = hold_q;
      parity_d   = (^hold_q) ^ (PARITY_ODD != 0);
      timer_d    = '0;
      bit_cnt_d  = '0;
      buf_full_d = 1'b0;
    end else if (bus.tx_valid && !buf_full_q) begin
      hold_d     = bus.tx_data;
      buf_full_d = 1'b1;
    end

    frame_done_d = frame_end;
    tx_busy_d    = (state_d != IDLE);
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = (SHIFT_MSB != 0) ? shift_d[DATA_BITS-1] : shift_d[0];
      PARITY:  tx_out_d = parity_d;
      default: tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      buf_full_q   <= 1'b0;
      parity_q     <= 1'b0;
      tx_out_q     <= 1'b1;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      buf_full_q   <= buf_full_d;
      parity_q     <= parity_d;
      tx_out_q     <= tx_out_d;
      tx_busy_q    <= tx_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.tx_ready = ~buf_full_q;
  assign tx_out       = tx_out_q;
  assign tx_busy      = tx_busy_q;
  assign frame_done   = frame_done_q;
endmodule
